// File: rtl/msg_scheduler.sv
// SHA-256 message schedule generator.
//
// Takes one 512-bit block as 16 32-bit words on a valid/ready stream. It emits
// W[0..15] as they are loaded, then expands the block and emits W[16..ROUNDS-1].
// Each word carries its round index. The downstream compressor only applies
// backpressure; this block owns the 16-word sliding window.
//
// Optional feature: define MSG_SCHED_BYTESWAP_EN to byte-reverse every accepted
// msg_word before it is used, so little-endian host words can be fed directly.
//
// Parameter:
//   ROUNDS     number of W words emitted per block (17..64)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle pulse that begins a block (sampled only in idle)
//   msg_word   incoming message word
//   msg_valid  msg_word is valid
//   msg_ready  scheduler accepts msg_word this cycle
//   w          current schedule word W[t] (registered)
//   w_round    round index t of the word on w (registered)
//   w_valid    w / w_round are valid
//   w_ready    downstream consumes w this cycle
//   busy       block in progress (load or expand, through the done cycle)
//   done       one-cycle pulse after W[ROUNDS-1] is consumed
module msg_scheduler #(
  parameter int unsigned ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] msg_word,
  input  logic        msg_valid,
  output logic        msg_ready,
  output logic [31:0] w,
  output logic [5:0]  w_round,
  output logic        w_valid,
  input  logic        w_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {StIdle, StLoad, StExpand} state_e;

  localparam logic [6:0] RoundsCnt = 7'(ROUNDS);

  state_e      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [31:0] w_q, w_d;
  logic [5:0]  round_q, round_d;
  logic        w_valid_q, w_valid_d;
  logic        done_q, done_d;

  // win_q[15] is the newest word, win_q[0] the oldest (W[t-16] while expanding).
  logic [31:0] win_q [16];
  logic        push;
  logic [31:0] push_word;

  logic        out_free;
  logic [31:0] msg_in;
  logic [31:0] expand_word;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

`ifdef MSG_SCHED_BYTESWAP_EN
  assign msg_in = {msg_word[7:0], msg_word[15:8], msg_word[23:16], msg_word[31:24]};
`else
  assign msg_in = msg_word;
`endif

  // Output register may take a new word when empty or being consumed this cycle.
  assign out_free = !w_valid_q || w_ready;

  // Taps relative to the word being generated: t-2, t-7, t-15, t-16.
  assign expand_word = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    w_d       = w_q;
    round_d   = round_q;
    w_valid_d = w_valid_q;
    done_d    = 1'b0;
    push      = 1'b0;
    push_word = msg_in;
    msg_ready = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          cnt_d   = 7'd0;
        end
      end

      StLoad: begin
        msg_ready = out_free;
        if (msg_valid && out_free) begin
          push      = 1'b1;
          push_word = msg_in;
          w_d       = msg_in;
          round_d   = cnt_q[5:0];
          w_valid_d = 1'b1;
          cnt_d     = cnt_q + 7'd1;
          if (cnt_q == 7'd15) begin
            state_d = StExpand;
          end
        end else if (out_free) begin
          // Pending word consumed with nothing to replace it.
          w_valid_d = 1'b0;
        end
      end

      StExpand: begin
        if (cnt_q < RoundsCnt) begin
          if (out_free) begin
            push      = 1'b1;
            push_word = expand_word;
            w_d       = expand_word;
            round_d   = cnt_q[5:0];
            w_valid_d = 1'b1;
            cnt_d     = cnt_q + 7'd1;
          end
        end else if (w_valid_q && w_ready) begin
          // Last word leaves the output register: block complete.
          w_valid_d = 1'b0;
          done_d    = 1'b1;
          state_d   = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 7'd0;
      w_q       <= 32'd0;
      round_q   <= 6'd0;
      w_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      w_q       <= w_d;
      round_q   <= round_d;
      w_valid_q <= w_valid_d;
      done_q    <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= 32'd0;
      end
    end else if (push) begin
      for (int i = 0; i < 15; i++) begin
        win_q[i] <= win_q[i+1];
      end
      win_q[15] <= push_word;
    end
  end

  assign w       = w_q;
  assign w_round = round_q;
  assign w_valid = w_valid_q;
  assign done    = done_q;
  assign busy    = (state_q != StIdle) || done_q;

endmodule

// File: tb/tb_msg_scheduler.sv
module tb_msg_scheduler;

  localparam int unsigned ROUNDS = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] msg_word = 32'd0;
  logic        msg_valid = 1'b0;
  logic        msg_ready;
  logic [31:0] w;
  logic [5:0]  w_round;
  logic        w_valid;
  logic        w_ready = 1'b0;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  msg_scheduler #(.ROUNDS(ROUNDS)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .msg_word (msg_word),
    .msg_valid(msg_valid),
    .msg_ready(msg_ready),
    .w        (w),
    .w_round  (w_round),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .busy     (busy),
    .done     (done)
  );

  typedef struct packed {
    logic [5:0]  r;
    logic [31:0] w;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          extra_words = 0;
  bit          mon_en = 1'b0;
  bit          rdy_rand = 1'b0;
  bit          abc_mode = 1'b0;
  bit          lat_mode = 1'b0;
  bit          done_pend = 1'b0;
  bit          exp_done_now = 1'b0;
  bit          hold_pend = 1'b0;
  logic [31:0] hold_w;
  logic [5:0]  hold_r;
  logic [31:0] blk [16];
  logic [31:0] ew [64];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model.
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] host(input logic [31:0] x);
`ifdef MSG_SCHED_BYTESWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction

  task automatic build_and_push();
    exp_t e;
    for (int t = 0; t < 16; t++) ew[t] = blk[t];
    for (int t = 16; t < 64; t++) ew[t] = s1(ew[t-2]) + ew[t-7] + s0(ew[t-15]) + ew[t-16];
    for (int t = 0; t < int'(ROUNDS); t++) begin
      e.r = 6'(t);
      e.w = ew[t];
      q.push_back(e);
    end
  endtask

  task automatic abc_block();
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  task automatic rand_block();
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    w_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Output monitor / scoreboard.
  always @(negedge clk) begin
    if (!mon_en) begin
      done_pend = 1'b0;
      hold_pend = 1'b0;
    end else begin
      exp_done_now = done_pend;
      done_pend = 1'b0;
      if (hold_pend) begin
        check_eq("hold_w", w, hold_w);
        check_eq("hold_round", w_round, hold_r);
      end
      if (w_valid && w_ready) begin
        if (q.size() == 0) begin
          extra_words++;
        end else begin
          exp_t e;
          e = q.pop_front();
          check_eq("w", w, e.w);
          check_eq("w_round", w_round, e.r);
        end
        if (abc_mode) begin
          if (w_round == 6'd16) check_eq("abc_w16", w, 32'h61626380);
          if (w_round == 6'd17) check_eq("abc_w17", w, 32'h000F0000);
          if (w_round == 6'd18) check_eq("abc_w18", w, 32'h7DA86405);
        end
        if (w_round == 6'(ROUNDS - 1)) begin
          done_pend = 1'b1;
          if (lat_mode) check_eq("latency", cyc + 1 - start_cyc, ROUNDS + 1);
        end
      end
      if (done || exp_done_now) check_eq("done", done, exp_done_now);
      hold_pend = w_valid && !w_ready;
      hold_w = w;
      hold_r = w_round;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] x);
    bit ok;
    ok = 1'b0;
    msg_valid = 1'b1;
    msg_word = x;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (msg_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("msg_ready_timeout", msg_ready, 1);
    @(posedge clk);
    #1;
    msg_valid = 1'b0;
  endtask

  task automatic send_block(input int gap_after, input int gap_len);
    for (int i = 0; i < 16; i++) begin
      send_word(host(blk[i]));
      if (i == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          check_eq("gap_msg_ready", msg_ready, 1);
          if (g >= 1) check_eq("gap_w_valid", w_valid, 0);
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        check_eq("busy_at_done", busy, 1);
        break;
      end
    end
    check_eq("done_seen", seen, 1);
    @(negedge clk);
    check_eq("busy_after_done", busy, 0);
    check_eq("queue_drained", q.size(), 0);
    q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_w", w, 0);
    check_eq("rst_w_round", w_round, 0);
    check_eq("rst_w_valid", w_valid, 0);
    check_eq("rst_msg_ready", msg_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // "abc" block, w_ready held high, latency measured.
    abc_block();
    abc_mode = 1'b1;
    lat_mode = 1'b1;
    build_and_push();
    pulse_start();
    check_eq("busy_after_start", busy, 1);
    send_block(-1, 0);
    wait_done();
    lat_mode = 1'b0;

    // Same block with random backpressure.
    rdy_rand = 1'b1;
    build_and_push();
    pulse_start();
    send_block(-1, 0);
    wait_done();

    // Gap of 3 idle cycles after word 5.
    rdy_rand = 1'b0;
    build_and_push();
    pulse_start();
    send_block(5, 3);
    wait_done();
    abc_mode = 1'b0;

    // start pulsed during expansion must be ignored.
    rdy_rand = 1'b1;
    rand_block();
    build_and_push();
    pulse_start();
    send_block(-1, 0);
    repeat (5) @(posedge clk);
    #1;
    pulse_start();
    wait_done();

    // Reset asserted at round 30, then a fresh block.
    rdy_rand = 1'b0;
    rand_block();
    build_and_push();
    pulse_start();
    send_block(-1, 0);
    begin
      bit found;
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (w_valid && w_round == 6'd30) begin
          found = 1'b1;
          break;
        end
      end
      check_eq("round30_seen", found, 1);
    end
    #1;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("abort_w", w, 0);
    check_eq("abort_w_round", w_round, 0);
    check_eq("abort_w_valid", w_valid, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_msg_ready", msg_ready, 0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rand_block();
    build_and_push();
    pulse_start();
    send_block(-1, 0);
    wait_done();

    check_eq("extra_words", extra_words, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/msg_scheduler.md
Name: msg_scheduler

Overview:
- Producer of the per-round message schedule word W for the SHA-256 round datapath.
- Accepts one 512-bit block as 16 32-bit words over a valid/ready stream, emits W[0..15] as loaded, then expands and emits W[16..63].
- Each W is tagged with its round index; the downstream compressor consumes one W per accepted handshake.
- Owns the 16-word sliding window; the compressor only supplies backpressure.

Parameters:
- ROUNDS, 64, total W words emitted per block; legal range 17..64. The 6-bit round field caps it at 64.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse, begins a block; sampled only in IDLE.
- msg_word  in  32  incoming message word, big-endian SHA word order.
- msg_valid  in  1  msg_word valid.
- msg_ready  out  1  scheduler accepts msg_word this cycle.
- w  out  32  current schedule word W[t] (registered).
- w_round  out  6  t for the word on w (registered).
- w_valid  out  1  w/w_round valid.
- w_ready  in  1  downstream consumes w this cycle.
- busy  out  1  high in LOAD or EXPAND.
- done  out  1  one-cycle pulse, the cycle after W[ROUNDS-1] is consumed.

Behaviour:
- Reset (async assert, sync release): state=IDLE; w=0, w_round=0, w_valid=0, msg_ready=0, busy=0, done=0; window cleared; counters=0.
- Output register advances when out_free = !w_valid || w_ready.
- States:
  - IDLE: start -> LOAD, cnt=0. start is ignored in LOAD/EXPAND (no restart, no error).
  - LOAD: msg_ready = out_free (combinational).
    - On msg_valid && msg_ready: w<=msg_word, w_round<=cnt, w_valid<=1, word shifted into window, cnt++.
    - After the 16th word is accepted -> EXPAND.
    - If no word is accepted, w_valid drops once w_ready consumes the pending word.
  - EXPAND: msg_ready=0.
    - Next word = sigma1(win[t-2]) + win[t-7] + sigma0(win[t-15]) + win[t-16], mod 2^32.
    - sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3; sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
    - On out_free, a new word is loaded into w with w_valid=1 and w_round=cnt, pushed into the window, cnt++.
    - After the word with cnt=ROUNDS-1 is loaded, generation stops.
    - When that word is consumed (w_valid && w_ready): w_valid<=0, done<=1 for one cycle, state -> IDLE.
- Hold rule: while w_valid && !w_ready, w, w_round and the window are frozen; no word is lost or duplicated.
- Throughput: 1 word/cycle with w_ready held high; W[0] appears on w one cycle after its msg handshake.
- Latency: start to W[ROUNDS-1] consumed = ROUNDS+1 cycles minimum with no stalls.
- busy: high from the cycle after start through the cycle done is asserted.
- Simultaneous events: w_ready and msg_valid in the same cycle is a normal overlap (consume plus refill). A start coinciding with done's cycle is accepted only once the state is IDLE, i.e. the following cycle.
- Reset mid-block: immediate abort to reset values; a partial block is discarded; no done.
- Counter: cnt is 7 bits internally; w_round is cnt[5:0]. No wrap within a block.

Optional Feature:
- Macro: MSG_SCHED_BYTESWAP_EN.
- Defined: each accepted msg_word is byte-reversed ({b0,b1,b2,b3}) before use, so little-endian host words can be fed directly.
- Undefined: msg_word is used unmodified.
- Expansion and all timing are identical either way.

Test Plan:
- "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1 -> W16=0x61626380, W17=0x000F0000, W18=0x7DA86405; w_round 0..63 in order; done one cycle after round 63 consumed; total ROUNDS+1 cycles.
- Same block, w_ready toggled 1/0 pseudo-randomly -> identical 64-word sequence to the golden model; w stable while stalled; no duplicate or missing rounds.
- msg_valid gaps during LOAD (3 idle cycles after word 5) -> msg_ready unaffected, w_valid drops during the gap, sequence still correct.
- rst_n asserted at round 30 -> outputs zero immediately; a new start with a fresh block produces the correct sequence; no done from the aborted block.
- start pulsed during EXPAND -> ignored; the current block completes unchanged.
- With MSG_SCHED_BYTESWAP_EN, msg_word=0x80636261 for word 0 -> w=0x61626380 at round 0.
